ubbcl_limb_sequencer: RTL
=========================

# ubbcl_limb_sequencer

Multi-cycle wide-operand adder controller. It sequences one shared 11-bit block carry look-ahead primitive with carry input, `PriMBCLA_10_0`, over `LIMBS` consecutive 11-bit limbs. A registered carry is chained between limbs, giving an `(11*LIMBS)`-bit addition with a `(11*LIMBS+1)`-bit result. It sits between a start/done command interface and the single adder instance, so wide additions reuse one 11-bit datapath.

## Interface

**Parameters**
- `LIMBS`, default 4: number of 11-bit limbs; legal range 1..16. `W = 11*LIMBS`.

**Ports**
- `CLK` input, 1 bit: clock; rising edge active.
- `RST` input, 1 bit: reset; asynchronous, active-high.
- `START` input, 1 bit: operation request; sampled only while idle.
- `X` input, W bits: operand 1; captured on the accepting edge.
- `Y` input, W bits: operand 2; captured on the accepting edge.
- `SUB` input, 1 bit: subtract select. Present only with `LIMB_SEQ_SUB_EN`.
- `BUSY` output, 1 bit: operation in progress.
- `DONE` output, 1 bit: one-cycle pulse when `S` is updated.
- `S` output, W+1 bits: result; bit W is the final carry.

## Operation

**State machine**
- Two states: `IDLE` and `RUN`.
- `IDLE` → `RUN` on an edge with `START=1`. That edge:
  - captures X into `opx` and Y into `opy`,
  - sets `carry` to the initial carry (0 for add),
  - sets `cnt` to 0,
  - sets `BUSY` to 1.
- Each `RUN` edge:
  - The adder computes `sum[11:0] = opx[10:0] + opy[10:0] + carry`.
  - `acc` shifts right by 11 with `sum[10:0]` inserted at the top.
  - `opx` and `opy` shift right by 11.
  - `carry` takes `sum[11]`.
  - `cnt` increments.
- `RUN` → `IDLE` on the edge where `cnt == LIMBS-1`. That edge:
  - loads `S` with `{sum[11], sum[10:0], acc[W-1:11]}`; for `LIMBS=1`, `S = sum`,
  - clears `BUSY`,
  - sets `DONE` to 1.

**Command handling**
- `START` while `BUSY=1` is ignored. No queueing, no error.
- `X` and `Y` may change freely after the accepting edge.
- `S` holds its value until the next completion. It is never updated with partial results.
- Arithmetic is unsigned modulo 2^(W+1). The W+1 bit result is always exact for add.

## Timing

**Reset**
- `RST` asserted: all outputs are 0 (`BUSY=0`, `DONE=0`, `S=0`).
- Internal registers (`opx`, `opy`, `acc`, `carry`, `cnt`) clear; state is `IDLE`.

**Latency and throughput**
- Latency: the accepting edge is e0. `BUSY` is high from e0 through e`LIMBS`. `DONE` and the new `S` appear after edge e`LIMBS`, so `DONE` is high for exactly one cycle.
- Throughput: `START` may be held high continuously, or reasserted in the `DONE` cycle. It is accepted at e`LIMBS+1`, giving one operation per `LIMBS+1` cycles.

**Boundary cases**
- `RST` mid-operation aborts immediately. `S` clears to 0 with no `DONE` pulse.
- The first `START` after reset release is accepted normally.
- `DONE` is never asserted while `BUSY=1` in the same cycle.

## Configuration

Macro `LIMB_SEQ_SUB_EN`.

**Defined**
- The `SUB` port exists and is captured with the operands.
- With `SUB=1`:
  - `opy` captures `~Y`,
  - the initial carry is 1,
  - the result is `X - Y` modulo 2^W.
- `S[W]` is then the no-borrow flag: 1 when X ≥ Y.
- With `SUB=0`, behaviour is identical to the add-only build.

**Undefined**
- No `SUB` port.
- The initial carry is always 0.
- The block performs addition only.

## Test plan

All scenarios use `LIMBS=4` (W=44).

1. Reset mid-run: accept X=5, Y=3, then assert `RST` at e2 → `BUSY=0`, `DONE=0`, `S=0` immediately. Next `START` with X=1, Y=2 → `S=3` with correct latency.
2. Basic add: X=5, Y=3, `START` one cycle → `BUSY` high for 4 cycles, then `DONE`=1 for 1 cycle with `S=0x008`.
3. Full carry ripple across all limbs: X=0xFFFFFFFFFFF, Y=1 → `S=0x100000000000`. Also X=Y=0xFFFFFFFFFFF → `S=0x1FFFFFFFFFFE`.
4. Busy lockout: `START` at e0 with X=1, Y=1, then `START` at e2 with X=7, Y=7 → only one `DONE`, with `S=2`. `BUSY` never re-extends.
5. Back-to-back: `START` held high with X=0x7FF, Y=0x001 → `DONE` every 5 cycles, each with `S=0x800`. Operand changes take effect only at acceptance.
6. With `LIMB_SEQ_SUB_EN`:
   - `SUB=1`, X=10, Y=3 → `S[43:0]=7`, `S[44]=1`.
   - `SUB=1`, X=3, Y=10 → `S[43:0]=0xFFFFFFFFFF9`, `S[44]=0`.

Source files
------------

// File: rtl/ubbcl_limb_sequencer_if.sv
// Command/result bundle for ubbcl_limb_sequencer.
// START/X/Y (and SUB when LIMB_SEQ_SUB_EN is defined) flow from the requester
// to the sequencer. BUSY/DONE/S flow back to the requester.
interface ubbcl_limb_sequencer_if #(
  parameter int LIMBS = 4
);
  localparam int W = 11 * LIMBS;

  logic         START;
  logic [W-1:0] X;
  logic [W-1:0] Y;
`ifdef LIMB_SEQ_SUB_EN
  logic         SUB;
`endif
  logic         BUSY;
  logic         DONE;
  logic [W:0]   S;

  modport master (
    output START, X, Y,
`ifdef LIMB_SEQ_SUB_EN
    output SUB,
`endif
    input  BUSY, DONE, S
  );

  modport slave (
    input  START, X, Y,
`ifdef LIMB_SEQ_SUB_EN
    input  SUB,
`endif
    output BUSY, DONE, S
  );
endinterface

// File: rtl/ubbcl_limb_sequencer.sv
// ubbcl_limb_sequencer: wide (11*LIMBS)-bit adder built from one 11-bit
// carry look-ahead block. The block is reused once per limb, least significant
// limb first, and the carry is registered between limbs.
// Optional feature macro: LIMB_SEQ_SUB_EN adds the SUB input. When SUB=1,
// X - Y is computed as X + ~Y + 1. S[W] is then the no-borrow flag.
module ubbcl_limb_sequencer #(
  parameter int LIMBS = 4
) (
  input logic                   CLK,
  input logic                   RST,
  ubbcl_limb_sequencer_if.slave bus
);
  localparam int W  = 11 * LIMBS;
  localparam int CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LIMBS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 11-bit block carry look-ahead primitive with carry in.
  // Returns {carry_out, sum[10:0]}.
  function automatic logic [11:0] pri_mbcla_10_0(
    input logic [10:0] a,
    input logic [10:0] b,
    input logic        ci
  );
    logic [10:0] g;
    logic [10:0] p;
    logic [11:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    for (int i = 0; i < 11; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[11], p ^ c[10:0]};
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic            accept_s;
  logic            step_s;
  logic            finish_s;

  logic [W-1:0]    opx_r;
  logic [W-1:0]    opy_r;
  logic [W-1:0]    acc_r;
  logic            carry_r;
  logic [CW-1:0]   cnt_r;
  logic            busy_r;
  logic            done_r;
  logic [W:0]      s_r;

  logic [11:0]     sum_s;
  logic [W+10:0]   acc_shift_s;
  logic [W-1:0]    acc_nxt_s;
  logic [W-1:0]    opy_in_s;
  logic            carry_in_s;

  // The shared limb adder works on the low limb of the shifting operands.
  assign sum_s       = pri_mbcla_10_0(opx_r[10:0], opy_r[10:0], carry_r);
  // The new limb enters at the top. The oldest limb ends up at bit 0 after
  // LIMBS steps. The wide concatenation keeps LIMBS=1 free of empty slices.
  assign acc_shift_s = {sum_s[10:0], acc_r};
  assign acc_nxt_s   = acc_shift_s[W+10:11];

`ifdef LIMB_SEQ_SUB_EN
  // Subtraction is addition of the one's complement with an initial carry of 1.
  always_comb begin
    if (bus.SUB) begin
      opy_in_s   = ~bus.Y;
      carry_in_s = 1'b1;
    end else begin
      opy_in_s   = bus.Y;
      carry_in_s = 1'b0;
    end
  end
`else
  assign opy_in_s   = bus.Y;
  assign carry_in_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-edge control decode.
  // START is only looked at while idle, so requests during a run are dropped.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.START) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, limb stepping and result/flag registers.
  // S is written only on the final step, so partial sums never reach it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      opx_r   <= {W{1'b0}};
      opy_r   <= {W{1'b0}};
      acc_r   <= {W{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      s_r     <= {(W+1){1'b0}};
    end else begin
      busy_r <= (state_nxt_s == ST_RUN);
      done_r <= finish_s;
      if (accept_s) begin
        opx_r   <= bus.X;
        opy_r   <= opy_in_s;
        carry_r <= carry_in_s;
        cnt_r   <= {CW{1'b0}};
      end else if (step_s) begin
        opx_r   <= opx_r >> 4'd11;
        opy_r   <= opy_r >> 4'd11;
        carry_r <= sum_s[11];
        cnt_r   <= cnt_r + CW'(1);
        acc_r   <= acc_nxt_s;
      end else begin
        opx_r   <= opx_r;
        opy_r   <= opy_r;
        carry_r <= carry_r;
        cnt_r   <= cnt_r;
        acc_r   <= acc_r;
      end
      if (finish_s) begin
        s_r <= {sum_s[11], acc_nxt_s};
      end else begin
        s_r <= s_r;
      end
    end
  end

  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;
  assign bus.S    = s_r;

endmodule
